// File: rtl/hs4_rx_fifo.sv
// Clocked receiver for the self-timed stage3 pipeline: four-phase req/ack in, FIFO, valid/ready out.
// Define HS4_RX_SYNC3_EN for a 3-flop req_in synchronizer (default is 2 flops).
module hs4_rx_fifo #(
    parameter  int DW    = 3,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_in,
    input  logic [DW-1:0] data_in,
    output logic          ack_out,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [DW-1:0] data_out,
    output logic [AW:0]   level
);

`ifdef HS4_RX_SYNC3_EN
    localparam int SYNC_LEN = 3;
`else
    localparam int SYNC_LEN = 2;
`endif

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t               state, state_nx;
    logic [SYNC_LEN-1:0]  req_sync;
    logic                 req_s;
    logic                 push, pop;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DW-1:0]        mem [DEPTH];

    // req_in is asynchronous to clk; only the last flop of the chain is used.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_LEN-2:0], req_in};
        end
    end

    assign req_s = req_sync[SYNC_LEN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Full check uses the registered level, so a same-cycle pop never frees space for a push.
    // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && (level != FULL_LEVEL)) begin
                    push     = 1'b1;
                    state_nx = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign ack_out   = (state == ACK);
    assign valid_out = (level != '0);
    assign pop       = valid_out && ready_in;

    // NOTE: memory is reset here because data_out must read zero out of reset; plain
    // storage arrays normally stay unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign data_out = mem[rd_ptr];

endmodule

// File: tb/tb_hs4_rx_fifo.sv
// Directed bench for hs4_rx_fifo: handshake latency, backpressure, streaming, reset abort, wrap.
module tb_hs4_rx_fifo;

`ifdef HS4_RX_SYNC3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_in;
    logic [2:0] data_in;
    logic       ack_out;
    logic       valid_out;
    logic       ready_in;
    logic [2:0] data_out;
    logic [2:0] level;

    int errors = 0;
    int checks = 0;

    logic       mon_en = 1'b0;
    logic [2:0] max_level;
    logic [2:0] got_q[$];
    logic [2:0] exp_q[$];

    hs4_rx_fifo #(.DW(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Records words popped at the coming edge, then advances to 1 time unit past it.
    task automatic tick();
        if (mon_en && valid_out && ready_in) got_q.push_back(data_out);
        @(posedge clk);
        #1;
        if (mon_en && level > max_level) max_level = level;
    endtask

    task automatic wait_ack(input logic v, input string tag);
        int n = 0;
        while (ack_out !== v && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(ack_out), 32'(v));
    endtask

    task automatic handshake(input logic [2:0] d, input int hold);
        data_in = d;
        req_in  = 1'b1;
        wait_ack(1'b1, "ack_rise");
        repeat (hold) tick();
        req_in = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        req_in   = 1'b0;
        data_in  = 3'd0;
        ready_in = 1'b0;
        repeat (2) tick();
        check("rst_ack", 32'(ack_out), 32'(0));
        check("rst_valid", 32'(valid_out), 32'(0));
        check("rst_data", 32'(data_out), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        rst_n = 1'b1;
        tick();

        // Single handshake: exact rise and fall latency.
        data_in = 3'b001;
        req_in  = 1'b1;
        repeat (LAT - 1) tick();
        check("t1_ack_early", 32'(ack_out), 32'(0));
        check("t1_valid_early", 32'(valid_out), 32'(0));
        tick();
        check("t1_ack", 32'(ack_out), 32'(1));
        check("t1_valid", 32'(valid_out), 32'(1));
        check("t1_data", 32'(data_out), 32'(1));
        check("t1_level", 32'(level), 32'(1));
        req_in = 1'b0;
        repeat (LAT - 1) tick();
        check("t1_ack_hold", 32'(ack_out), 32'(1));
        tick();
        check("t1_ack_fall", 32'(ack_out), 32'(0));
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check("t1_drained", 32'(level), 32'(0));

        // Fill to DEPTH, fifth request is held off until a pop.
        for (int i = 1; i <= 4; i++) handshake(3'(i), 0);
        check("t2_full", 32'(level), 32'(4));
        data_in = 3'b101;
        req_in  = 1'b1;
        repeat (10) tick();
        check("t2_bp_ack", 32'(ack_out), 32'(0));
        check("t2_bp_level", 32'(level), 32'(4));
        check("t2_head", 32'(data_out), 32'(1));
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check("t2_pop_level", 32'(level), 32'(3));
        check("t2_pop_head", 32'(data_out), 32'(2));
        tick();
        check("t2_acked", 32'(ack_out), 32'(1));
        check("t2_refull", 32'(level), 32'(4));
        req_in = 1'b0;
        wait_ack(1'b0, "t2_ack_fall");
        for (int i = 2; i <= 5; i++) begin
            check("t2_drain_valid", 32'(valid_out), 32'(1));
            check("t2_drain_data", 32'(data_out), 32'(i));
            ready_in = 1'b1;
            tick();
        end
        ready_in = 1'b0;
        check("t2_empty_level", 32'(level), 32'(0));
        check("t2_empty_valid", 32'(valid_out), 32'(0));

        // Streaming with ready_in held: in order, occupancy at most 1.
        got_q.delete();
        exp_q = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        max_level = 3'd0;
        ready_in  = 1'b1;
        mon_en    = 1'b1;
        foreach (exp_q[i]) handshake(exp_q[i], 0);
        repeat (3) tick();
        mon_en   = 1'b0;
        ready_in = 1'b0;
        compare_stream("t3_stream");
        check("t3_max_level", 32'(max_level), 32'(1));
        check("t3_level", 32'(level), 32'(0));

        // Long req_in high after ack: exactly one push.
        handshake(3'b010, 20);
        check("t4_one_push", 32'(level), 32'(1));

        // Asynchronous reset in ACK with two words queued; req_in stays high.
        data_in = 3'b011;
        req_in  = 1'b1;
        wait_ack(1'b1, "t5_ack");
        check("t5_level_pre", 32'(level), 32'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ack", 32'(ack_out), 32'(0));
        check("t5_rst_valid", 32'(valid_out), 32'(0));
        check("t5_rst_data", 32'(data_out), 32'(0));
        check("t5_rst_level", 32'(level), 32'(0));
        tick();
        rst_n = 1'b1;
        repeat (LAT) tick();
        check("t5_recapture_ack", 32'(ack_out), 32'(1));
        check("t5_recapture_level", 32'(level), 32'(1));
        check("t5_recapture_data", 32'(data_out), 32'(3));
        req_in = 1'b0;
        wait_ack(1'b0, "t5_ack_fall");

        // Same-edge push and pop at level 2, then stream across pointer wrap.
        handshake(3'b100, 0);
        check("t6_level2", 32'(level), 32'(2));
        got_q.delete();
        mon_en  = 1'b1;
        data_in = 3'b101;
        req_in  = 1'b1;
        repeat (LAT - 1) tick();
        check("t6_pre_level", 32'(level), 32'(2));
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check("t6_pushpop_ack", 32'(ack_out), 32'(1));
        check("t6_pushpop_level", 32'(level), 32'(2));
        check("t6_pushpop_head", 32'(data_out), 32'(4));
        req_in = 1'b0;
        wait_ack(1'b0, "t6_ack_fall");
        ready_in = 1'b1;
        for (int i = 6; i < 14; i++) handshake(3'(i), 0);
        repeat (3) tick();
        mon_en   = 1'b0;
        ready_in = 1'b0;
        exp_q = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        compare_stream("t6_wrap");
        check("t6_final_level", 32'(level), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
